vdp_trace_capture: RTL and testbench

Sink-side companion to the Van der Pol Euler solver: consumes the solver's per-cycle (x, u, t) sample stream, stores a decimated trajectory in an internal buffer, tracks positive-going zero crossings and peak of x, then drains the buffer to a host over a valid/ready read port. It sits between the solver outputs and the host or debug readout logic. All data is signed Q16.16.

---
 rtl/vdp_trace_capture_if.sv | 27 ++
 rtl/vdp_trace_capture.sv | 167 ++++++++++++++++
 tb/tb_vdp_trace_capture.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_trace_capture_if.sv
// Sample stream from the Van der Pol solver and the host read port of the trace capture block.
// The capture block is the slave; the solver/host side is the master.
interface vdp_trace_capture_if #(
    parameter int W = 32
);
    logic [W-1:0] in_x;
    logic [W-1:0] in_u;
    logic [W-1:0] in_t;
    logic         in_valid;
    logic         in_done;
    logic         rd_ready;
    logic         rd_valid;
    logic [W-1:0] rd_x;
    logic [W-1:0] rd_u;
    logic [W-1:0] rd_t;
    logic         rd_last;

    modport master (
        output in_x, in_u, in_t, in_valid, in_done, rd_ready,
        input  rd_valid, rd_x, rd_u, rd_t, rd_last
    );

    modport slave (
        input  in_x, in_u, in_t, in_valid, in_done, rd_ready,
        output rd_valid, rd_x, rd_u, rd_t, rd_last
    );
endinterface

// File: rtl/vdp_trace_capture.sv
// Decimating trajectory capture for the Van der Pol solver: buffers (x, u, t) samples,
// tracks x zero crossings and peak, then drains the buffer over a valid/ready read port.
module vdp_trace_capture #(
    parameter int ADDR_W = 8,
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic [15:0]         decim,
    vdp_trace_capture_if.slave  bus,
    output logic                busy,
    output logic                overflow,
    output logic [ADDR_W:0]     count,
    output logic [15:0]         zc_count,
    output logic [W-1:0]        x_peak
);
    localparam int             DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL    = DEPTH[ADDR_W:0];
    localparam logic [W-1:0]   PEAK_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READOUT} state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     zc_q, zc_d;
    logic [W-1:0]    peak_q, peak_d;
    logic [15:0]     dcnt_q, dcnt_d;
    logic [15:0]     decim_q, decim_d;
    logic            have_prev_q, have_prev_d;
    logic            prev_neg_q, prev_neg_d;

    logic            mem_we;
    logic [3*W-1:0]  mem [DEPTH];
    logic [3*W-1:0]  mem_rd;
    logic            rd_valid;
    logic            rd_last;

    // The write address is the stored-sample count, so no separate write pointer is kept.
    // NOTE: the buffer has no reset; its contents only matter below count, which is reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[count_q[ADDR_W-1:0]] <= {bus.in_x, bus.in_u, bus.in_t};
        end
    end

    always_comb begin
        mem_rd       = mem[rd_ptr_q[ADDR_W-1:0]];
        rd_valid     = (state_q == S_READOUT) && (rd_ptr_q < count_q);
        rd_last      = rd_valid && (rd_ptr_q == count_q - (ADDR_W+1)'(1));
        bus.rd_valid = rd_valid;
        bus.rd_last  = rd_last;
        bus.rd_x     = rd_valid ? mem_rd[3*W-1:2*W] : '0;
        bus.rd_u     = rd_valid ? mem_rd[2*W-1:W]   : '0;
        bus.rd_t     = rd_valid ? mem_rd[W-1:0]     : '0;
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        zc_d        = zc_q;
        peak_d      = peak_q;
        dcnt_d      = dcnt_q;
        decim_d     = decim_q;
        have_prev_d = have_prev_q;
        prev_neg_d  = prev_neg_q;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d     = S_CAPTURE;
                    count_d     = '0;
                    rd_ptr_d    = '0;
                    overflow_d  = 1'b0;
                    zc_d        = '0;
                    peak_d      = PEAK_MIN;
                    dcnt_d      = '0;
                    decim_d     = decim;
                    have_prev_d = 1'b0;
                    prev_neg_d  = 1'b0;
                end
            end

            S_CAPTURE: begin
                if (bus.in_valid) begin
                    // Statistics see every sample, decimated or not.
                    if ($signed(bus.in_x) > $signed(peak_q)) begin
                        peak_d = bus.in_x;
                    end
                    if (have_prev_q && prev_neg_q && !bus.in_x[W-1] && (zc_q != 16'hFFFF)) begin
                        zc_d = zc_q + 16'd1;
                    end
                    prev_neg_d  = bus.in_x[W-1];
                    have_prev_d = 1'b1;

                    if ((dcnt_q == 16'd0) || bus.in_done) begin
                        dcnt_d = decim_q;
                        if (count_q == FULL) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            count_d = count_q + (ADDR_W+1)'(1);
                        end
                    end else begin
                        dcnt_d = dcnt_q - 16'd1;
                    end

                    if (bus.in_done) begin
                        state_d = S_READOUT;
                    end
                end
            end

            S_READOUT: begin
                if (rd_valid && bus.rd_ready) begin
                    rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
                    if (rd_last) begin
                        state_d = S_IDLE;
                    end
                end else if (!rd_valid) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            zc_q        <= '0;
            peak_q      <= PEAK_MIN;
            dcnt_q      <= '0;
            decim_q     <= '0;
            have_prev_q <= 1'b0;
            prev_neg_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            zc_q        <= zc_d;
            peak_q      <= peak_d;
            dcnt_q      <= dcnt_d;
            decim_q     <= decim_d;
            have_prev_q <= have_prev_d;
            prev_neg_q  <= prev_neg_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;
    assign count    = count_q;
    assign zc_count = zc_q;
    assign x_peak   = peak_q;
endmodule

// File: tb/tb_vdp_trace_capture.sv
// Randomized self-checking bench for vdp_trace_capture against a queue-based model of
// decimation, buffering, zero-crossing count and peak tracking.
module tb_vdp_trace_capture;
    localparam int ADDR_W = 3;
    localparam int W      = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] u;
        logic [W-1:0] t;
    } samp_t;

    logic              clk;
    logic              rst_n;
    logic              arm;
    logic [15:0]       decim;
    logic              busy;
    logic              overflow;
    logic [ADDR_W:0]   count;
    logic [15:0]       zc_count;
    logic [W-1:0]      x_peak;

    vdp_trace_capture_if #(.W(W)) bus ();

    vdp_trace_capture #(.ADDR_W(ADDR_W), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .decim    (decim),
        .bus      (bus),
        .busy     (busy),
        .overflow (overflow),
        .count    (count),
        .zc_count (zc_count),
        .x_peak   (x_peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    samp_t src_q[$];
    samp_t exp_q[$];
    int    exp_ovf;
    int    exp_zc;
    logic  [W-1:0] exp_peak;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_done  = 1'b0;
        bus.in_x     = '0;
        bus.in_u     = '0;
        bus.in_t     = '0;
        bus.rd_ready = 1'b0;
    endtask

    // Model: sample i is kept when i is a multiple of decim+1 or is the done sample,
    // until the buffer holds DEPTH entries.
    task automatic build_model(input int d);
        logic signed [W-1:0] pk;
        int last;
        exp_q.delete();
        exp_ovf = 0;
        exp_zc  = 0;
        pk      = {1'b1, {(W-1){1'b0}}};
        last    = src_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if ((i % (d + 1)) == 0 || i == last) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(src_q[i]);
                else exp_ovf = 1;
            end
            if ($signed(src_q[i].x) > pk) pk = src_q[i].x;
            if (i > 0 && $signed(src_q[i-1].x) < 0 && $signed(src_q[i].x) >= 0 && exp_zc < 16'hFFFF)
                exp_zc++;
        end
        exp_peak = pk;
    endtask

    task automatic capture(input int d, input bit gaps);
        int last;
        build_model(d);
        last = src_q.size() - 1;
        // A sample present in the arm cycle must not be captured.
        arm          = 1'b1;
        decim        = 16'(d);
        bus.in_valid = 1'b1;
        bus.in_done  = 1'b0;
        bus.in_x     = 32'h7FFF_0000;
        tick();
        arm = 1'b0;
        for (int i = 0; i <= last; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0;
                    bus.in_done  = ($urandom_range(0, 1) == 1);
                    bus.in_x     = 32'h7FFF_FFFF;
                    tick();
                end
            end
            bus.in_valid = 1'b1;
            bus.in_done  = (i == last);
            bus.in_x     = src_q[i].x;
            bus.in_u     = src_q[i].u;
            bus.in_t     = src_q[i].t;
            tick();
        end
        // Held solver inputs during readout must be ignored.
        bus.in_valid = 1'b1;
        bus.in_done  = 1'b1;
        bus.in_x     = 32'h7FFF_FFFF;

        total++;
        if (count !== (ADDR_W+1)'(exp_q.size()) || overflow !== 1'(exp_ovf)) begin
            bad++;
            $display("FAIL capture_count: count=%0d ovf=%0b expected count=%0d ovf=%0d",
                     count, overflow, exp_q.size(), exp_ovf);
        end
        total++;
        if (zc_count !== 16'(exp_zc) || x_peak !== exp_peak) begin
            bad++;
            $display("FAIL capture_stats: zc=%0d peak=%h expected zc=%0d peak=%h",
                     zc_count, x_peak, exp_zc, exp_peak);
        end
        total++;
        if (busy !== 1'b1 || bus.rd_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_rd_valid: busy=%0b rd_valid=%0b expected 1 1", busy, bus.rd_valid);
        end
    endtask

    // mode 0: ready held high, 1: ready toggles starting low, 2: random ready.
    task automatic drain(input int mode, input int exp_cycles);
        int idx = 0;
        int cyc = 0;
        bit fire;
        samp_t e;
        while (idx < exp_q.size() && cyc < 500) begin
            case (mode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = ((cyc % 2) == 1);
                default: bus.rd_ready = ($urandom_range(0, 1) == 1);
            endcase
            e = exp_q[idx];
            total++;
            if (bus.rd_valid !== 1'b1 || bus.rd_x !== e.x || bus.rd_u !== e.u || bus.rd_t !== e.t ||
                bus.rd_last !== (idx == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL beat%0d: v=%0b x=%h u=%h t=%h last=%0b expected x=%h u=%h t=%h last=%0b",
                         idx, bus.rd_valid, bus.rd_x, bus.rd_u, bus.rd_t, bus.rd_last,
                         e.x, e.u, e.t, idx == exp_q.size() - 1);
            end
            fire = (bus.rd_valid === 1'b1) && bus.rd_ready;
            tick();
            cyc++;
            if (fire) idx++;
        end
        bus.rd_ready = 1'b0;
        total++;
        if (idx != exp_q.size()) begin
            bad++;
            $display("FAIL drain_timeout: beats=%0d expected %0d", idx, exp_q.size());
        end
        if (exp_cycles > 0) begin
            total++;
            if (cyc != exp_cycles) begin
                bad++;
                $display("FAIL drain_cycles: cycles=%0d expected %0d", cyc, exp_cycles);
            end
        end
        total++;
        if (busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_x !== '0 || bus.rd_last !== 1'b0 ||
            count !== (ADDR_W+1)'(exp_q.size()) || zc_count !== 16'(exp_zc) || x_peak !== exp_peak) begin
            bad++;
            $display("FAIL post_drain: busy=%0b v=%0b x=%h last=%0b count=%0d zc=%0d peak=%h",
                     busy, bus.rd_valid, bus.rd_x, bus.rd_last, count, zc_count, x_peak);
        end
        bus.in_valid = 1'b0;
        bus.in_done  = 1'b0;
        tick();
    endtask

    task automatic push_samp(input logic [W-1:0] x);
        samp_t s;
        s.x = x;
        s.u = $urandom;
        s.t = $urandom;
        src_q.push_back(s);
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (busy !== 1'b0 || overflow !== 1'b0 || count !== '0 || zc_count !== '0 ||
            x_peak !== 32'h8000_0000 || bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 ||
            bus.rd_x !== '0 || bus.rd_u !== '0 || bus.rd_t !== '0) begin
            bad++;
            $display("FAIL %s: busy=%0b ovf=%0b count=%0d zc=%0d peak=%h v=%0b last=%0b x=%h",
                     tag, busy, overflow, count, zc_count, x_peak, bus.rd_valid, bus.rd_last, bus.rd_x);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        decim = '0;
        rst_n = 1'b0;
        #23;
        check_reset_values("reset_values");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decim0();
        src_q.delete();
        for (int k = 0; k < 10; k++) push_samp(32'(k) << 16);
        src_q.delete();
        for (int k = 0; k < 8; k++) push_samp(32'(k) << 16);
        capture(0, 1'b0);
        drain(0, 8);
    endtask

    task automatic test_decim();
        src_q.delete();
        for (int k = 0; k < 10; k++) push_samp($urandom);
        capture(2, 1'b0);
        drain(0, 4);
        src_q.delete();
        for (int k = 0; k < 8; k++) push_samp($urandom);
        capture(2, 1'b0);
        drain(0, 4);
    endtask

    task automatic test_overflow();
        src_q.delete();
        for (int k = 0; k < DEPTH + 2; k++) push_samp(32'(k) << 16);
        capture(0, 1'b0);
        drain(0, DEPTH);
    endtask

    task automatic test_zero_cross();
        src_q.delete();
        push_samp(32'hFFFF_0000);
        push_samp(32'hFFFF_0000);
        push_samp(32'h0001_0000);
        push_samp(32'h0002_0000);
        push_samp(32'hFFFE_0000);
        push_samp(32'h0000_0000);
        capture(0, 1'b0);
        total++;
        if (zc_count !== 16'd2 || x_peak !== 32'h0002_0000) begin
            bad++;
            $display("FAIL zero_cross_fixed: zc=%0d peak=%h expected 2 00020000", zc_count, x_peak);
        end
        drain(0, 6);
    endtask

    task automatic test_backpressure();
        src_q.delete();
        for (int k = 0; k < DEPTH; k++) push_samp($urandom);
        capture(0, 1'b0);
        drain(1, 2 * DEPTH);
    endtask

    task automatic test_reset_mid();
        src_q.delete();
        arm          = 1'b1;
        decim        = 16'd0;
        tick();
        arm          = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_done  = 1'b0;
            bus.in_x     = 32'h0003_0000;
            tick();
        end
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_capture");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_values("after_reset_release");
        for (int k = 0; k < 3; k++) push_samp($urandom);
        capture(0, 1'b0);
        drain(0, 3);
    endtask

    task automatic test_random();
        int n;
        int d;
        for (int it = 0; it < 12; it++) begin
            src_q.delete();
            n = $urandom_range(1, 14);
            d = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) push_samp($urandom);
            capture(d, 1'b1);
            drain(2, 0);
        end
    endtask

    initial begin
        test_reset();
        test_decim0();
        test_decim();
        test_overflow();
        test_zero_cross();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
